// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point radix-2 DIT FFT core:
// sample format, Q1.14 twiddles, FSM states and the bit-reverse helper.
package fft_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int DATA_W = 16;
  localparam int TW_W   = 16;
  localparam int DW1    = DATA_W + 1;
  localparam int FRAC   = 14;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STAGE,
    DONE
  } state_t;

  // W8^k = exp(-j*2*pi*k/8) for k = 0..3, Q1.14
  localparam logic signed [TW_W-1:0] TW_RE [4] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
  localparam logic signed [TW_W-1:0] TW_IM [4] = '{16'sd0, -16'sd11585, -16'sd16384, -16'sd11585};

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2]};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Pipelined radix-2 butterfly: stage 1 registers t = b*W and a, stage 2 forms
// (a+t)/2 and (a-t)/2 combinationally for the caller to write back.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int TAG_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  cplx_t                   a,
  input  cplx_t                   b,
  input  logic signed [TW_W-1:0]  w_re,
  input  logic signed [TW_W-1:0]  w_im,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_tag,
  output cplx_t                   out_a,
  output cplx_t                   out_b
);

  localparam int PW = DATA_W + TW_W;

  logic signed [DATA_W-1:0] b_re, b_im, a_re, a_im;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [DW1-1:0]    t_re_d, t_im_d, t_re_q, t_im_q;
  logic signed [DW1-1:0]    sum_re, sum_im, dif_re, dif_im;
  cplx_t                    a_q;

  assign b_re = b.re;
  assign b_im = b.im;
  assign p_rr = PW'(b_re) * PW'(w_re);
  assign p_ii = PW'(b_im) * PW'(w_im);
  assign p_ri = PW'(b_re) * PW'(w_im);
  assign p_ir = PW'(b_im) * PW'(w_re);

  // Each product is truncated to integer before summing, not after.
  assign t_re_d = DW1'((p_rr >>> FRAC) - (p_ii >>> FRAC));
  assign t_im_d = DW1'((p_ri >>> FRAC) + (p_ir >>> FRAC));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      t_re_q    <= '0;
      t_im_q    <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      a_q       <= a;
      t_re_q    <= t_re_d;
      t_im_q    <= t_im_d;
      out_tag   <= in_tag;
      out_valid <= in_valid;
    end
  end

  assign a_re   = a_q.re;
  assign a_im   = a_q.im;
  assign sum_re = DW1'(a_re) + t_re_q;
  assign sum_im = DW1'(a_im) + t_im_q;
  assign dif_re = DW1'(a_re) - t_re_q;
  assign dif_im = DW1'(a_im) - t_im_q;

  assign out_a = '{re: DATA_W'(sum_re >>> 1), im: DATA_W'(sum_im >>> 1)};
  assign out_b = '{re: DATA_W'(dif_re >>> 1), im: DATA_W'(dif_im >>> 1)};

endmodule

// File: rtl/fft_pipeline_core.sv
// Board-level 8-point FFT: loads a built-in vector bit-reversed into bank0,
// runs 3 ping-pong butterfly stages, and exposes any word via the switches.
module fft_pipeline_core
  import fft_pkg::*;
(
  input  logic                     CLOCK_50,
  input  logic [3:0]               KEY,
  input  logic [7:0]               SW,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               stage,
  output logic signed [DATA_W-1:0] dout_re,
  output logic signed [DATA_W-1:0] dout_im
);

  localparam int TAG_W = 1 + 2 * LOG2N;

  logic clk, rst, en;
  logic unused_inputs;
  assign clk           = CLOCK_50;
  assign rst           = KEY[3];
  assign en            = SW[1];
  assign unused_inputs = ^{KEY[2:0], SW[6:5]};

  state_t     state_q, state_d;
  logic [2:0] cnt_q;
  logic [1:0] s_q;
  logic       vsel_q;

  cplx_t mem0 [N];
  cplx_t mem1 [N];

  logic [1:0]       j, k;
  logic [2:0]       top, bot;
  logic             rd_bank, issue;
  cplx_t            rd_a, rd_b, load_word, bf_a, bf_b, rd_word;
  logic             bf_valid;
  logic [TAG_W-1:0] bf_tag;
  logic             wr_bank;
  logic [2:0]       wr_top, wr_bot;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    if (en && cnt_q == 3'd7) state_d = STAGE;
      STAGE:   if (en && cnt_q == 3'd5 && s_q == 2'd2) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      s_q    <= '0;
      vsel_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          vsel_q <= SW[7];
          cnt_q  <= '0;
          s_q    <= '0;
        end
        LOAD: cnt_q <= cnt_q + 3'd1;
        STAGE: begin
          if (cnt_q == 3'd5) begin
            cnt_q <= '0;
            s_q   <= s_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Cycles 0..3 of a stage issue butterfly j; cycles 4..5 let the pipe drain.
  always_comb begin
    j   = cnt_q[1:0];
    top = '0;
    k   = '0;
    case (s_q)
      2'd0: begin
        top = {j, 1'b0};
        k   = 2'd0;
      end
      2'd1: begin
        top = {j[1], 1'b0, j[0]};
        k   = {j[0], 1'b0};
      end
      default: begin
        top = {1'b0, j};
        k   = j;
      end
    endcase
    bot       = top + (3'd1 << s_q);
    rd_bank   = s_q[0];
    rd_a      = rd_bank ? mem1[top] : mem0[top];
    rd_b      = rd_bank ? mem1[bot] : mem0[bot];
    issue     = en && (state_q == STAGE) && !cnt_q[2];
    load_word = '{re: (vsel_q || cnt_q == 3'd0) ? 16'sd1024 : 16'sd0, im: 16'sd0};
  end

  // bf_valid qualifies bf_tag/bf_a/bf_b; a result is consumed only on an
  // enabled cycle, so a stall simply holds it in place.
  fft_butterfly #(.TAG_W(TAG_W)) u_bf (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (issue),
    .a         (rd_a),
    .b         (rd_b),
    .w_re      (TW_RE[k]),
    .w_im      (TW_IM[k]),
    .in_tag    ({~rd_bank, top, bot}),
    .out_valid (bf_valid),
    .out_tag   (bf_tag),
    .out_a     (bf_a),
    .out_b     (bf_b)
  );

  assign {wr_bank, wr_top, wr_bot} = bf_tag;

  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (state_q == LOAD) mem0[bitrev3(cnt_q)] <= load_word;
      if (bf_valid) begin
        if (wr_bank) begin
          mem1[wr_top] <= bf_a;
          mem1[wr_bot] <= bf_b;
        end else begin
          mem0[wr_top] <= bf_a;
          mem0[wr_bot] <= bf_b;
        end
      end
    end
  end

  assign rd_word = SW[0] ? mem1[SW[4:2]] : mem0[SW[4:2]];

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_re <= '0;
      dout_im <= '0;
    end else begin
      dout_re <= rd_word.re;
      dout_im <= rd_word.im;
    end
  end

  assign busy  = (state_q == LOAD) || (state_q == STAGE);
  assign done  = (state_q == DONE);
  assign stage = (state_q == STAGE) ? s_q : 2'd0;

endmodule

// File: tb/tb_fft_pipeline_core.sv
// Directed bench for fft_pipeline_core: impulse/DC runs, stall, idle hold,
// mid-run abort and registered readout sweeps against hand-computed results.
module tb_fft_pipeline_core;

  logic               clk = 1'b0;
  logic [3:0]         key;
  logic [7:0]         sw;
  logic               busy, done;
  logic [1:0]         stage;
  logic signed [15:0] dout_re, dout_im;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  fft_pipeline_core dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .dout_re  (dout_re),
    .dout_im  (dout_im)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] sw_val);
    key = 4'h8;
    sw  = sw_val;
    tick();
    tick();
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_stage", {30'b0, stage}, 32'd0);
    check_eq("rst_dout_re", {16'b0, dout_re}, 32'd0);
    check_eq("rst_dout_im", {16'b0, dout_im}, 32'd0);
    key = 4'h0;
  endtask

  // Counts clock edges from the first busy cycle to done; -1 on timeout.
  task automatic run_until_done(input bit toggle, output int cycles);
    int start;
    bit seen;
    start  = 0;
    seen   = 1'b0;
    cycles = -1;
    for (int i = 0; i < 200; i++) begin
      sw[1] = toggle ? (i % 2 == 0) : 1'b1;
      tick();
      if (!seen && busy) begin
        seen  = 1'b1;
        start = i;
      end
      if (done) begin
        cycles = i - start;
        break;
      end
    end
  endtask

  // Hand-derived bank contents: kind 0 = impulse, kind 1 = DC(1024).
  function automatic logic [31:0] exp_word(input int kind, input logic bank, input int a);
    logic [15:0] re;
    if (kind == 0) re = bank ? 16'd128 : ((a < 4) ? 16'd256 : 16'd0);
    else re = bank ? ((a == 0) ? 16'd1024 : 16'd0) : ((a == 0 || a == 4) ? 16'd1024 : 16'd0);
    return {re, 16'd0};
  endfunction

  task automatic read_bank(input logic bank, input int kind, input string tag);
    logic [31:0] prev, exp;
    prev = '0;
    for (int a = 0; a < 8; a++) begin
      sw[0]   = bank;
      sw[4:2] = a[2:0];
      exp_q.push_back(exp_word(kind, bank, a));
      #1;
      if (a > 0) check_eq({tag, "_hold"}, {dout_re, dout_im}, prev);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check_eq({tag, "_re"}, {16'b0, dout_re}, {16'b0, exp[31:16]});
      check_eq({tag, "_im"}, {16'b0, dout_im}, {16'b0, exp[15:0]});
      prev = exp;
    end
  endtask

  task automatic check_finished(input string tag, input int cyc, input int exp_cyc);
    check_eq({tag, "_cycles"}, cyc, exp_cyc);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_stage"}, {30'b0, stage}, 32'd0);
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    key      = 4'h0;
    sw       = 8'h00;

    // impulse run, uninterrupted
    do_reset(8'h02);
    run_until_done(1'b0, cyc);
    check_finished("imp", cyc, 26);
    read_bank(1'b1, 0, "imp_b1");
    read_bank(1'b0, 0, "imp_b0");

    // enable low from reset: FSM idles, memory keeps the impulse results
    do_reset(8'h00);
    repeat (20) tick();
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
    check_eq("idle_done", {31'b0, done}, 32'd0);
    check_eq("idle_stage", {30'b0, stage}, 32'd0);
    read_bank(1'b1, 0, "idle_b1");

    // DC run
    do_reset(8'h82);
    run_until_done(1'b0, cyc);
    check_finished("dc", cyc, 26);
    read_bank(1'b1, 1, "dc_b1");
    read_bank(1'b0, 1, "dc_b0");

    // impulse run with 50% enable duty
    do_reset(8'h02);
    run_until_done(1'b1, cyc);
    check_finished("stall", cyc, 52);
    read_bank(1'b1, 0, "stall_b1");
    read_bank(1'b0, 0, "stall_b0");

    // abort a DC run in stage 1, then full impulse rerun
    do_reset(8'h82);
    for (int i = 0; i < 100; i++) begin
      sw[1] = 1'b1;
      tick();
      if (stage == 2'd1) break;
    end
    check_eq("abort_stage", {30'b0, stage}, 32'd1);
    check_eq("abort_busy", {31'b0, busy}, 32'd1);
    do_reset(8'h02);
    run_until_done(1'b0, cyc);
    check_finished("rerun", cyc, 26);
    read_bank(1'b1, 0, "rerun_b1");
    read_bank(1'b0, 0, "rerun_b0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_pipeline_core.md
Name: fft_pipeline_core

Overview:
- Self-contained 8-point radix-2 decimation-in-time FFT engine for the board top level.
- Loads a built-in test vector into a ping-pong sample memory in bit-reversed order, then runs 3 butterfly stages that alternate between two banks.
- Exposes any result word through switch-selected readout ports.
- Board controls: SW[1] is run/stall, SW[0] selects the readout bank, SW[4:2] is the readout address, SW[7] selects the test vector.

Parameters:
- DATA_W, 16, signed sample width of each of the re and im parts.
- TW_W, 16, twiddle width in signed Q1.14.
- N, 8, FFT length; fixed, with LOG2N = 3.

Ports:
- CLOCK_50  in  1  single system clock; all logic is on its rising edge.
- KEY  in  4  KEY[3] is the reset: synchronous, active-high. KEY[2:0] are unused.
- SW  in  8  [0] readout bank select; [1] run enable; [4:2] readout address; [6:5] unused; [7] test vector select.
- busy  out  1  high while in LOAD or STAGE.
- done  out  1  high in DONE.
- stage  out  2  current stage index (0..2); 0 outside STAGE.
- dout_re  out  DATA_W  real part of the readout word, signed.
- dout_im  out  DATA_W  imaginary part of the readout word, signed.

Behaviour:
- Reset (KEY[3]=1 at a clock edge):
  - FSM goes to IDLE.
  - busy, done, stage, dout_re and dout_im are all 0.
  - Pipeline registers are cleared. Memory contents are not reset.
  - Reset mid-operation aborts immediately.
- Global enable en = SW[1]. When en=0, the FSM, counters and butterfly pipeline registers all hold, with no memory writes. Readout is unaffected by en.
- IDLE: when en=1, go to LOAD and latch SW[7] as vsel.
- LOAD: 8 enabled cycles, counter i = 0..7.
  - Write bank0[bitrev3(i)] = vec(i), with im = 0.
  - vsel=0 gives an impulse: vec(0)=1024, all others 0.
  - vsel=1 gives DC: vec(i)=1024 for all i.
  - Then go to STAGE with s=0.
- STAGE s: read bank s%2 and write bank (s+1)%2.
  - Issue butterflies j = 0..3, one per enabled cycle.
  - Addressing: h = 1<<s; top = (j>>s)*2h + (j&(h-1)); bot = top + h; twiddle index k = (j&(h-1))<<(2-s).
  - Butterfly latency is 2 enabled cycles: cycle 1 registers t = b*W[k], cycle 2 writes both results.
  - Each stage takes 6 enabled cycles: 4 issue plus 2 drain. After s=2, go to DONE.
- Butterfly arithmetic:
  - Complex multiply with full-precision products. Each product is arithmetic-shifted right 14 (truncation), then summed.
  - a' = (a + t) >>> 1 and b' = (a - t) >>> 1, computed at DATA_W+1 bits and then truncated to DATA_W.
  - Net scaling of the transform is 1/8.
- Twiddles W8^k in Q1.14:
  - k0 = (16384, 0)
  - k1 = (11585, -11585)
  - k2 = (0, -16384)
  - k3 = (-11585, -11585)
- Final results are in bank1. Total time is 26 enabled cycles from leaving IDLE to done=1.
- DONE holds until reset; it does not restart.
- Readout:
  - dout = bank[SW[0]][SW[4:2]], registered, with 1-cycle latency.
  - Readout is valid in any state, and SW may change every cycle.
- Stalling via SW[1] toggling at any rate yields results identical to a run without stalls.

Decomposition:
- Package fft_pkg contains:
  - N, LOG2N, DATA_W and TW_W constants.
  - The complex sample struct.
  - The twiddle constant array.
  - The FSM state enum: IDLE, LOAD, STAGE, DONE.
  - A bitrev3 function.
- One sub-module, fft_butterfly: 2-stage pipelined complex butterfly with an enable input.

Test Plan:
- Reset with SW=8'h02 (vsel=0), then hold until done → after 26 cycles done=1 and busy=0. Reading bank1 addresses 0..7 gives dout_re=128 and dout_im=0 for every bin.
- SW[7]=1 (DC 1024) → bank1[0] = (1024, 0); bank1[1..7] = (0, 0).
- SW[1] toggling every cycle during the run (50 % duty) → done after 52 cycles, with results identical to the uninterrupted run.
- SW[1]=0 from reset → FSM stays in IDLE, busy=0, done=0, and readout reflects the unchanged memory.
- Reset asserted mid-STAGE (s=1), then released with SW[1]=1 → full rerun, done at 26 cycles, results correct.
- Readout sweep with SW[0]=0 after the vsel=1 run → bank0 holds the stage-1 output, bank0[0] = (1024, 0). Each readout appears exactly 1 cycle after the SW change.
